// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer
//  Description : CPU-mapped 16-bit down-counting timer with a power-of-two
//                prescaler, optional auto-reload and a maskable interrupt.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in     1  system clock, rising-edge active
//    reset        in     1  synchronous, active-high reset
//    data_bus     inout 16  shared CPU data bus (driven only on reads)
//    address_bus  in     2  register select
//    enable       in     1  chip select
//    write        in     1  CPU write strobe
//    read         in     1  CPU read strobe
//    irq          out    1  interrupt request (pending && irq_en, registered)
//
//  Register map
//    0 COUNT  r/w  16-bit down counter
//    1 RELOAD r/w  16-bit reload value
//    2 CTRL   r/w  bit0 run, bit1 auto_reload, bit2 irq_en, bits[6:4] N
//    3 STATUS      bit0 pending, write 1 to clear
// ============================================================================
module timer #(
  parameter int PRESCALE_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] data_bus,
  input  logic [1:0]  address_bus,
  input  logic        enable,
  input  logic        write,
  input  logic        read,
  output logic        irq
);

  localparam logic [1:0] c_ADDR_COUNT  = 2'd0;
  localparam logic [1:0] c_ADDR_RELOAD = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS = 2'd3;

  // Compare width must hold 2^7 - 1 even if the prescaler is configured
  // narrower, so the limit never truncates for the largest N.
  localparam int c_CMP_W = (PRESCALE_W > 8) ? PRESCALE_W + 1 : 9;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0]           count_q,     count_d;
  logic [15:0]           reload_q,    reload_d;
  logic                  run_q,       run_d;
  logic                  auto_q,      auto_d;
  logic                  irq_en_q,    irq_en_d;
  logic [2:0]            presc_n_q,   presc_n_d;
  logic                  pending_q,   pending_d;
  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic                  irq_q;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_count;
  logic        w_wr_reload;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic [15:0] w_rdata;

  assign w_wr        = enable && write;
  assign w_rd        = enable && read && !write;
  assign w_wr_count  = w_wr && (address_bus == c_ADDR_COUNT);
  assign w_wr_reload = w_wr && (address_bus == c_ADDR_RELOAD);
  assign w_wr_ctrl   = w_wr && (address_bus == c_ADDR_CTRL);
  assign w_wr_status = w_wr && (address_bus == c_ADDR_STATUS);

  always_comb begin
    w_rdata = 16'd0;
    case (address_bus)
      c_ADDR_COUNT:  w_rdata = count_q;
      c_ADDR_RELOAD: w_rdata = reload_q;
      c_ADDR_CTRL:   w_rdata = {9'd0, presc_n_q, 1'b0, irq_en_q, auto_q, run_q};
      c_ADDR_STATUS: w_rdata = {15'd0, pending_q};
      default:       w_rdata = 16'd0;
    endcase
  end

  // Reads are purely combinational from the current register contents, so
  // they behave identically while reset is asserted.
  assign data_bus = w_rd ? w_rdata : 16'hzzzz;

  // --------------------------------------------------------------------------
  // Prescaler tick and expiry
  // --------------------------------------------------------------------------
  logic [c_CMP_W-1:0] w_limit;
  logic               w_tick;
  logic               w_expire;

  assign w_limit  = (c_CMP_W'(1) << presc_n_q) - c_CMP_W'(1);
  assign w_tick   = run_q && (c_CMP_W'(prescaler_q) == w_limit);
  assign w_expire = w_tick && (count_q == 16'd0);

  // --------------------------------------------------------------------------
  // Next-state logic. Ordering inside this block encodes priority: timer
  // events first, then bus writes override them, except that an expiry
  // always wins over a STATUS clear.
  // --------------------------------------------------------------------------
  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    run_d       = run_q;
    auto_d      = auto_q;
    irq_en_d    = irq_en_q;
    presc_n_d   = presc_n_q;
    pending_d   = pending_q;

    // Held at zero when stopped; wraps to zero on every tick.
    prescaler_d = '0;
    if (run_q && !w_tick) begin
      prescaler_d = prescaler_q + PRESCALE_W'(1);
    end

    if (w_tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end else begin
        // One-shot: stop and leave COUNT parked at zero.
        run_d = 1'b0;
      end
    end

    if (w_wr_status && data_bus[0]) begin
      pending_d = 1'b0;
    end
    if (w_expire) begin
      pending_d = 1'b1;
    end

    if (w_wr_count) begin
      count_d     = data_bus;
      prescaler_d = '0;
    end

    if (w_wr_reload) begin
      reload_d = data_bus;
    end

    if (w_wr_ctrl) begin
      run_d       = data_bus[0];
      auto_d      = data_bus[1];
      irq_en_d    = data_bus[2];
      presc_n_d   = data_bus[6:4];
      prescaler_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 16'd0;
      reload_q    <= 16'd0;
      run_q       <= 1'b0;
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      presc_n_q   <= 3'd0;
      pending_q   <= 1'b0;
      prescaler_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      run_q       <= run_d;
      auto_q      <= auto_d;
      irq_en_q    <= irq_en_d;
      presc_n_q   <= presc_n_d;
      pending_q   <= pending_d;
      prescaler_q <= prescaler_d;
      // Built from next-state values so irq rises together with pending,
      // i.e. in the cycle right after the expiry.
      irq_q       <= pending_d && irq_en_d;
    end
  end

  assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer
//  Description : Randomised and directed bench for timer, checked against a
//                behavioural model through a read scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address_bus = 2'd0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_data = 16'd0;
  wire  [15:0] data_bus;
  wire         irq;

  assign data_bus = tb_drv ? tb_data : 16'hzzzz;

  timer #(.PRESCALE_W(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_bus    (data_bus),
    .address_bus (address_bus),
    .enable      (enable),
    .write       (write),
    .read        (read),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        irq;
    logic [1:0]  addr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // --------------------------------------------------------------------------
  // Behavioural model: plain integers, prescaler as a phase modulo 2^N
  // --------------------------------------------------------------------------
  int unsigned m_count = 0, m_reload = 0, m_phase = 0, m_n = 0;
  bit m_run = 0, m_auto = 0, m_irqen = 0, m_pending = 0, m_irq = 0;

  function automatic bit m_tick();
    return m_run && (((m_phase + 1) % (1 << m_n)) == 0);
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] a);
    int unsigned v;
    case (a)
      2'd0:    v = m_count;
      2'd1:    v = m_reload;
      2'd2:    v = m_n * 16 + (m_irqen ? 4 : 0) + (m_auto ? 2 : 0) + (m_run ? 1 : 0);
      default: v = m_pending ? 1 : 0;
    endcase
    return 16'(v);
  endfunction

  function automatic void m_step(input bit rst, input bit en, input bit wr,
                                 input logic [1:0] a, input logic [15:0] d);
    bit tick, expire, nrun, npend;
    int unsigned nc, np;
    if (rst) begin
      m_count = 0; m_reload = 0; m_phase = 0; m_n = 0;
      m_run = 0; m_auto = 0; m_irqen = 0; m_pending = 0; m_irq = 0;
      return;
    end
    tick   = m_tick();
    expire = tick && (m_count == 0);
    nc     = m_count;
    nrun   = m_run;
    npend  = m_pending;
    np     = m_run ? (m_phase + 1) % (1 << m_n) : 0;
    if (tick) nc = (m_count == 0) ? (m_auto ? m_reload : 0) : m_count - 1;
    if (expire && !m_auto) nrun = 0;
    if (en && wr && a == 2'd3 && d[0]) npend = 0;
    if (expire) npend = 1;
    m_count = nc; m_run = nrun; m_pending = npend; m_phase = np;
    if (en && wr) begin
      case (a)
        2'd0: begin m_count = int'(d); m_phase = 0; end
        2'd1: m_reload = int'(d);
        2'd2: begin
          m_run = d[0]; m_auto = d[1]; m_irqen = d[2];
          m_n = int'(d[6:4]); m_phase = 0;
        end
        default: ;
      endcase
    end
    m_irq = m_pending && m_irqen;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers: one bus cycle each, inputs change 1 time unit after
  // the rising edge; expected read data is queued from the pre-edge model.
  // --------------------------------------------------------------------------
  task automatic cyc(input bit rst, input bit en, input bit wr, input bit rd,
                     input logic [1:0] a, input logic [15:0] d);
    reset = rst; enable = en; write = wr; read = rd; address_bus = a;
    tb_data = d; tb_drv = en && wr;
    if (en && rd && !wr) sb.push_back('{m_read(a), m_irq, a});
    @(posedge clk);
    m_step(rst, en, wr, a, d);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 16'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  // Bus must float when the chip is not selected: drive a known value from
  // the bench and expect to see exactly it.
  task automatic check_float(input logic [15:0] v);
    reset = 1'b0; enable = 1'b0; write = 1'b0; read = 1'b1; address_bus = 2'd0;
    tb_data = v; tb_drv = 1'b1;
    @(negedge clk);
    checks++;
    if (data_bus !== v) begin
      failures++;
      $display("FAIL bus_float: data_bus=%h required=%h", data_bus, v);
    end
    @(posedge clk);
    m_step(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    #1;
    tb_drv = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pops an expectation whenever the DUT drives the bus
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (enable && read && !write) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: DUT drove data_bus=%h with no expectation", data_bus);
      end else begin
        mon_e = sb.pop_front();
        if (data_bus !== mon_e.data || irq !== mon_e.irq) begin
          failures++;
          $display("FAIL read_reg%0d: data=%h irq=%b required data=%h irq=%b at %0t",
                   mon_e.addr, data_bus, irq, mon_e.data, mon_e.irq, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin : main
    bit found;
    logic [1:0]  a;
    logic [15:0] d;
    int op;

    // Reset, read all registers, float check
    @(posedge clk); #1;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    for (int i = 0; i < 4; i++) rd_reg(2'(i));
    check_float(16'hA5A5);

    // Float check with a non-zero register behind the selected address
    wr_reg(2'd0, 16'h1234);
    check_float(16'h0000);

    // One-shot: COUNT=3, run + irq_en, N=0
    wr_reg(2'd0, 16'd3);
    wr_reg(2'd2, 16'h0005);
    repeat (5) rd_reg(2'd0);
    rd_reg(2'd3);
    rd_reg(2'd2);
    repeat (2) rd_reg(2'd0);

    // Auto-reload: RELOAD=2, COUNT=0, N=2
    wr_reg(2'd1, 16'd2);
    wr_reg(2'd0, 16'd0);
    wr_reg(2'd3, 16'h0001);
    wr_reg(2'd2, 16'h0027);
    for (int i = 0; i < 30; i++) rd_reg((i % 3 == 2) ? 2'd3 : 2'd0);

    // STATUS clear coinciding with expiry: set wins
    wr_reg(2'd3, 16'h0001);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_tick() && m_count == 0) begin
        wr_reg(2'd3, 16'h0001);
        found = 1'b1;
      end else begin
        rd_reg(2'd3);
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL expiry_search: found=%b required=1", found);
    end
    rd_reg(2'd3);
    wr_reg(2'd3, 16'h0001);
    rd_reg(2'd3);
    wr_reg(2'd3, 16'h0000);
    rd_reg(2'd3);

    // COUNT write on a tick cycle: write wins, prescaler restarts
    wr_reg(2'd2, 16'h0000);
    wr_reg(2'd0, 16'h0100);
    wr_reg(2'd2, 16'h0013);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_tick()) begin
        wr_reg(2'd0, 16'h0010);
        found = 1'b1;
      end else begin
        rd_reg(2'd0);
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL tick_search: found=%b required=1", found);
    end
    repeat (5) rd_reg(2'd0);

    // Reset mid-count with a simultaneous CTRL write
    wr_reg(2'd2, 16'h0007);
    rd_reg(2'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0077);
    for (int i = 0; i < 4; i++) rd_reg(2'(i));

    // RELOAD=0 with auto-reload: expiry on every tick
    wr_reg(2'd1, 16'd0);
    wr_reg(2'd0, 16'd0);
    wr_reg(2'd2, 16'h0007);
    rd_reg(2'd3);
    wr_reg(2'd3, 16'h0001);
    rd_reg(2'd3);
    rd_reg(2'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 99));
      a  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      if (a == 2'd0 || a == 2'd1) d = 16'($urandom_range(0, 12));
      if (a == 2'd2) d[6:4] = 3'($urandom_range(0, 2));
      if (op < 2)       cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, a, d);
      else if (op < 22) wr_reg(a, d);
      else if (op < 80) rd_reg(a);
      else if (op < 85) cyc(1'b0, 1'b1, 1'b1, 1'b1, a, d);
      else if (op < 90) cyc(1'b0, 1'b0, 1'b1, 1'b0, a, d);
      else              idle();
    end

    idle();
    idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk and reset.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- data_bus  inout  16  shared CPU data bus
- address_bus  input  2  register select (CPU address bits [1:0])
- enable  input  1  chip select, decoded externally
- write  input  1  CPU write strobe
- read  input  1  CPU read strobe
- irq  output  1  interrupt request; wired to one CPU interrupts bit
REQ-003 Parameters SHALL be, one per line (name, default, meaning):
- PRESCALE_W  7  prescaler counter width

Function
REQ-004 Register map SHALL be:
- 0 COUNT: r/w, 16 bit
- 1 RELOAD: r/w, 16 bit
- 2 CTRL: r/w; bit0 run, bit1 auto_reload, bit2 irq_en, bits[6:4] prescale N; other bits read 0
- 3 STATUS: bit0 pending; write 1 clears it; other bits read 0
REQ-005 Read: data_bus SHALL be driven combinationally with the selected register while enable && read && !write; otherwise it SHALL be high-Z.
REQ-006 Write: the register SHALL be updated on the rising clk when enable && write; the new value SHALL be readable the following cycle.
REQ-007 Prescaler: while run=1, the prescaler SHALL increment every clk; a tick SHALL occur when prescaler == 2^N-1, and the prescaler SHALL then wrap to 0; N=0 SHALL tick every cycle.
REQ-008 While run=0, the prescaler SHALL be held at 0 and COUNT SHALL be frozen.
REQ-009 Any write to CTRL or COUNT SHALL clear the prescaler to 0.
REQ-010 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-011 On a tick with COUNT == 0 (expiry):
- pending SHALL be set
- if auto_reload=1, COUNT SHALL load RELOAD
- if auto_reload=0, run SHALL clear and COUNT SHALL stay 0
REQ-012 COUNT SHALL never wrap from 0 to 0xFFFF.
REQ-013 irq SHALL equal pending && irq_en, registered, and SHALL be high the cycle after expiry.
REQ-014 Simultaneous events:
- a bus write to COUNT on a tick cycle: the write SHALL win
- a STATUS clear on an expiry cycle: set SHALL win
- a CTRL write on an expiry cycle: the written CTRL value SHALL win, and pending SHALL still be set
REQ-015 Writing 0 to STATUS bit0 SHALL have no effect.
REQ-016 RELOAD=0 with auto_reload=1 SHALL produce an expiry on every tick.

Reset
REQ-017 When reset is high at a rising clk, the following SHALL be cleared to 0, overriding any bus write in the same cycle: COUNT, RELOAD, CTRL, pending, prescaler, irq.
REQ-018 During reset, data_bus SHALL follow REQ-005; a timer running mid-count SHALL stop immediately.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Reset, then read all four registers -> each returns 0x0000; irq=0; data_bus=Z when enable=0.
- COUNT=3, CTRL=0x0005 (run, irq_en, N=0) -> COUNT reads 2,1,0 on successive cycles; pending and irq set at the 4th tick; run clears; COUNT stays 0.
- RELOAD=2, COUNT=0, CTRL=0x0027 (N=2, auto-reload) -> expiry every 12 clks; COUNT sequence 2,1,0 changes every 4 clks.
- Expiry cycle coincides with a STATUS write of 0x0001 -> pending stays 1; a STATUS write of 0x0001 on a later cycle -> pending=0 and irq=0 the next cycle.
- COUNT write of 0x0010 on a tick cycle -> COUNT reads 0x0010, not 0x000F; prescaler restarts from 0.
- Reset asserted mid-count with a simultaneous CTRL write -> all registers read 0; irq=0 the next cycle.
